// File: rtl/hamming_secded_checker.sv
// hamming_secded_checker: two-stage SEC-DED(22,16) check/correct with saturating error statistics
module hamming_secded_checker #(
    parameter int CNT_W      = 8,
    parameter int CORRECT_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic [5:0]       in_check,
    input  logic             clr_counts,
    output logic             out_valid,
    output logic [15:0]      out_data,
    output logic [4:0]       out_syndrome,
    output logic             out_sec,
    output logic             out_ded,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count,
    output logic             ded_sticky
);
    function automatic logic [4:0] dpos(input int i);
        return (i == 0) ? 5'd3 : (i < 4) ? 5'(i + 4) : (i < 11) ? 5'(i + 5) : 5'(i + 6);
    endfunction

    logic             v1_q, par1_q, par_d;
    logic [15:0]      data1_q, data_d;
    logic [4:0]       syn1_q, syn_d;
    logic             out_valid_q, out_sec_q, out_ded_q, sec_d, ded_d, fix;
    logic [15:0]      out_data_q;
    logic [4:0]       out_syndrome_q;
    logic [CNT_W-1:0] sec_cnt_q, ded_cnt_q, sec_cnt_d, ded_cnt_d;
    logic             sticky_q, sticky_d;

    // Syndrome is the XOR of the positions of every set bit, so a clean codeword gives zero.
    always_comb begin
        syn_d = '0;
        for (int i = 0; i < 16; i++) syn_d ^= in_data[i] ? dpos(i) : 5'd0;
        for (int i = 0; i < 5; i++) syn_d ^= in_check[i] ? 5'(1 << i) : 5'd0;
        par_d = ^{in_data, in_check};
    end

    always_comb begin
        sec_d  = par1_q && (syn1_q <= 5'd21);
        ded_d  = par1_q ? (syn1_q > 5'd21) : (syn1_q != 5'd0);
        fix    = sec_d && (CORRECT_EN != 0) && ((syn1_q & (syn1_q - 5'd1)) != 5'd0);
        data_d = data1_q;
        for (int i = 0; i < 16; i++) data_d[i] = data1_q[i] ^ (fix && dpos(i) == syn1_q);
        sec_cnt_d = clr_counts ? '0 : sec_cnt_q + CNT_W'(out_valid_q && out_sec_q && sec_cnt_q != '1);
        ded_cnt_d = clr_counts ? '0 : ded_cnt_q + CNT_W'(out_valid_q && out_ded_q && ded_cnt_q != '1);
        sticky_d  = !clr_counts && (sticky_q || (out_valid_q && out_ded_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q           <= 1'b0;
            par1_q         <= 1'b0;
            data1_q        <= '0;
            syn1_q         <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_syndrome_q <= '0;
            out_sec_q      <= 1'b0;
            out_ded_q      <= 1'b0;
            sec_cnt_q      <= '0;
            ded_cnt_q      <= '0;
            sticky_q       <= 1'b0;
        end else begin
            v1_q        <= in_valid;
            out_valid_q <= v1_q;
            if (in_valid) begin
                data1_q <= in_data;
                syn1_q  <= syn_d;
                par1_q  <= par_d;
            end
            if (v1_q) begin
                out_data_q     <= data_d;
                out_syndrome_q <= syn1_q;
                out_sec_q      <= sec_d;
                out_ded_q      <= ded_d;
            end
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_syndrome = out_syndrome_q;
    assign out_sec      = out_sec_q;
    assign out_ded      = out_ded_q;
    assign sec_count    = sec_cnt_q;
    assign ded_count    = ded_cnt_q;
    assign ded_sticky   = sticky_q;
endmodule

// File: tb/tb_hamming_secded_checker.sv
// tb_hamming_secded_checker: table vectors, directed corner sequences and random stream vs a reference model
module tb_hamming_secded_checker;
    localparam int CNT_W = 4;
    localparam int MAXC  = 15;
    localparam int POS[16] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19, 20, 21};

    logic             clk = 1'b0, rst = 1'b1, in_valid = 1'b0, clr_counts = 1'b0;
    logic [15:0]      in_data = '0;
    logic [5:0]       in_check = '0;
    logic             out_valid, out_sec, out_ded, ded_sticky;
    logic [15:0]      out_data;
    logic [4:0]       out_syndrome;
    logic [CNT_W-1:0] sec_count, ded_count;
    logic             out_valid0, out_sec0, out_ded0, ded_sticky0;
    logic [15:0]      out_data0;
    logic [4:0]       out_syndrome0;
    logic [CNT_W-1:0] sec_count0, ded_count0;

    hamming_secded_checker #(.CNT_W(CNT_W), .CORRECT_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_check(in_check),
        .clr_counts(clr_counts), .out_valid(out_valid), .out_data(out_data),
        .out_syndrome(out_syndrome), .out_sec(out_sec), .out_ded(out_ded),
        .sec_count(sec_count), .ded_count(ded_count), .ded_sticky(ded_sticky));

    hamming_secded_checker #(.CNT_W(CNT_W), .CORRECT_EN(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_check(in_check),
        .clr_counts(clr_counts), .out_valid(out_valid0), .out_data(out_data0),
        .out_syndrome(out_syndrome0), .out_sec(out_sec0), .out_ded(out_ded0),
        .sec_count(sec_count0), .ded_count(ded_count0), .ded_sticky(ded_sticky0));

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] d;
        logic [15:0] d0;
        logic [4:0]  s;
        logic        sec;
        logic        ded;
    } exp_t;

    typedef struct {
        logic [15:0] din;
        logic [5:0]  cin;
        logic [15:0] edata;
        logic [15:0] edata0;
        logic [4:0]  esyn;
        logic        esec;
        logic        eded;
    } vec_t;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] enc(input logic [15:0] d);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 16; j++) begin
                int p;
                p = POS[j];
                if (((p >> i) & 1) == 1) c[i] = c[i] ^ d[j];
            end
        c[5] = ^{d, c[4:0]};
        return c;
    endfunction

    // Decode from first principles: compare re-encoded checks, then classify by parity and position.
    function automatic exp_t model(input logic [15:0] d, input logic [5:0] c);
        exp_t e;
        logic [5:0] r;
        int si;
        r = enc(d);
        e.due = 0;
        e.s = r[4:0] ^ c[4:0];
        si = int'(e.s);
        e.d = d;
        e.d0 = d;
        e.sec = 1'b0;
        e.ded = 1'b0;
        if (^{d, c}) begin
            if (si <= 21) begin
                e.sec = 1'b1;
                for (int j = 0; j < 16; j++) if (POS[j] == si) e.d[j] = ~d[j];
            end else e.ded = 1'b1;
        end else if (si != 0) e.ded = 1'b1;
        return e;
    endfunction

    exp_t        q[$];
    int          cyc = 0, m_secc = 0, m_dedc = 0;
    bit          started = 0;
    logic        m_valid = 0, m_sec = 0, m_ded = 0, m_sticky = 0;
    logic [15:0] m_data = 0, m_data0 = 0;
    logic [4:0]  m_syn = 0;

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", out_valid, m_valid);
            chk("out_data", out_data, m_data);
            chk("out_data_nocorr", out_data0, m_data0);
            chk("out_syndrome", out_syndrome, m_syn);
            chk("out_sec", out_sec, m_sec);
            chk("out_ded", out_ded, m_ded);
            chk("sec_count", sec_count, m_secc);
            chk("ded_count", ded_count, m_dedc);
            chk("ded_sticky", ded_sticky, m_sticky);
        end
        if (rst) begin
            started = 1;
            q.delete();
            {m_valid, m_sec, m_ded, m_sticky} = '0;
            m_data = 0; m_data0 = 0; m_syn = 0; m_secc = 0; m_dedc = 0;
        end else if (started) begin
            if (clr_counts) begin
                m_secc = 0; m_dedc = 0; m_sticky = 0;
            end else begin
                if (m_valid && m_sec && m_secc < MAXC) m_secc++;
                if (m_valid && m_ded) begin
                    if (m_dedc < MAXC) m_dedc++;
                    m_sticky = 1;
                end
            end
            m_valid = 0;
            if (q.size() > 0 && q[0].due == cyc + 1) begin
                exp_t e;
                e = q.pop_front();
                m_valid = 1; m_data = e.d; m_data0 = e.d0; m_syn = e.s; m_sec = e.sec; m_ded = e.ded;
            end
            if (in_valid) begin
                exp_t e;
                e = model(in_data, in_check);
                e.due = cyc + 2;
                q.push_back(e);
            end
        end
        cyc++;
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic [5:0] c, input logic clr, input logic r);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; in_check = c; clr_counts = clr; rst = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 16'h0, 6'h0, 0, 0);
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{16'h0008, 6'h00, 16'h0000, 16'h0008, 5'd7,  1'b1, 1'b0};
        tbl[1] = '{16'h0000, 6'h20, 16'h0000, 16'h0000, 5'd0,  1'b1, 1'b0};
        tbl[2] = '{16'h0000, 6'h01, 16'h0000, 16'h0000, 5'd1,  1'b1, 1'b0};
        tbl[3] = '{16'h0003, 6'h00, 16'h0003, 16'h0003, 5'd6,  1'b0, 1'b1};
        tbl[4] = '{16'h0003, 6'h10, 16'h0003, 16'h0003, 5'd22, 1'b0, 1'b1};
        tbl[5] = '{16'h0001, 6'h23, 16'h0001, 16'h0001, 5'd0,  1'b0, 1'b0};
        tbl[6] = '{16'h0000, 6'h15, 16'h8000, 16'h0000, 5'd21, 1'b1, 1'b0};
        tbl[7] = '{16'h0000, 6'h10, 16'h0000, 16'h0000, 5'd16, 1'b1, 1'b0};
        tbl[8] = '{16'h0000, 6'h1F, 16'h0000, 16'h0000, 5'd31, 1'b0, 1'b1};

        drive(0, 16'h0, 6'h0, 0, 1);
        drive(0, 16'h0, 6'h0, 0, 1);
        idle(1);

        for (int i = 0; i <= 16'h2C; i++) drive(1, 16'(i), enc(16'(i)), 0, 0);
        idle(3);
        @(negedge clk);
        chk("clean_sec_count", sec_count, 0);
        chk("clean_ded_count", ded_count, 0);

        for (int i = 0; i < 9; i++) begin
            drive(1, tbl[i].din, tbl[i].cin, 0, 0);
            idle(2);
            @(negedge clk);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data, tbl[i].edata);
            chk("tbl_data_nocorr", out_data0, tbl[i].edata0);
            chk("tbl_syn", out_syndrome, tbl[i].esyn);
            chk("tbl_sec", out_sec, tbl[i].esec);
            chk("tbl_ded", out_ded, tbl[i].eded);
        end
        idle(1);
        @(negedge clk);
        chk("tbl_sticky", ded_sticky, 1);

        drive(0, 16'h0, 6'h0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            drive(1, d ^ (16'd1 << (i % 16)), enc(d), 0, 0);
        end
        idle(3);
        @(negedge clk);
        chk("sat_sec_count", sec_count, MAXC);
        chk("sat_ded_count", ded_count, 0);

        drive(1, 16'h0003, 6'h00, 0, 0);
        idle(3);
        @(negedge clk);
        chk("ded_one", ded_count, 1);
        drive(1, 16'h0003, 6'h00, 0, 0);
        idle(1);
        drive(0, 16'h0, 6'h0, 1, 0);
        @(negedge clk);
        chk("clr_retire_valid", out_valid, 1);
        idle(1);
        @(negedge clk);
        chk("clr_ded_count", ded_count, 0);
        chk("clr_sticky", ded_sticky, 0);
        chk("clr_sec_count", sec_count, 0);

        drive(1, 16'h0008, 6'h00, 0, 0);
        drive(0, 16'h0, 6'h0, 0, 1);
        idle(1);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sec_count", sec_count, 0);
        idle(1);
        @(negedge clk);
        chk("rst_drop", out_valid, 0);
        drive(1, 16'h1234, enc(16'h1234), 0, 0);
        idle(1);
        @(negedge clk);
        chk("post_rst_early", out_valid, 0);
        idle(1);
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", out_data, 16'h1234);

        for (int n = 0; n < 600; n++) begin
            logic [15:0] d;
            logic [21:0] cw;
            int k;
            d = 16'($urandom);
            cw = {enc(d), d};
            k = $urandom_range(2, 0);
            for (int f = 0; f < k; f++) cw[$urandom_range(21, 0)] ^= 1'b1;
            if ($urandom_range(15, 0) == 0) cw[21:16] = 6'($urandom);
            drive(($urandom_range(3, 0) != 0), cw[15:0], cw[21:16],
                  ($urandom_range(39, 0) == 0), ($urandom_range(149, 0) == 0));
        end
        idle(4);
        @(negedge clk);
        chk("drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hamming_secded_checker.md
Name: hamming_secded_checker

Overview:
- Downstream consumer of the Hamming-protected 16-bit counter stage.
- Accepts the 16-bit counter value plus its 6 stored check bits and recomputes the SEC-DED(22,16) syndrome.
- Corrects single-bit errors and flags double-bit errors.
- Keeps saturating error statistics with a sticky uncorrectable-error flag for the monitoring/top level.

Parameters:
- CNT_W, 8, width of each saturating error counter.
- CORRECT_EN, 1, 1 = flip the erroneous data bit on a single error; 0 = detect only, out_data = in_data.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data/in_check are sampled this cycle.
- in_data  input  16  received counter value.
- in_check  input  6  received check bits: [4:0] Hamming, [5] overall parity.
- clr_counts  input  1  synchronous clear of counters and sticky flag.
- out_valid  output  1  result valid, exactly 2 cycles after in_valid.
- out_data  output  16  corrected data.
- out_syndrome  output  5  recomputed syndrome.
- out_sec  output  1  single error detected (corrected if CORRECT_EN).
- out_ded  output  1  uncorrectable error detected.
- sec_count  output  CNT_W  saturating count of out_sec events.
- ded_count  output  CNT_W  saturating count of out_ded events.
- ded_sticky  output  1  set on any out_ded; held until clr_counts or rst.

Behaviour:

Codeword map (positions 1..21):
- Check bits sit at positions 1, 2, 4, 8, 16, driven by in_check[0..4].
- Data bits fill the remaining positions in ascending order:
  - data[0]=3, data[1]=5, data[2]=6, data[3]=7
  - data[4..10]=9..15
  - data[11..15]=17..21
- check[i] (i=0..4) = even parity over all data positions whose index has bit i set.
- check[5] = XOR of data[15:0] and check[4:0].

Stage 1 (register on in_valid):
- Register data and check.
- Compute syndrome s[4:0] = recomputed check[4:0] XOR received check[4:0].
- Compute p = XOR of all 22 received bits.

Stage 2 (classification):
- s==0, p==0: clean; sec=0, ded=0.
- p==1, s==0: error in check[5]; sec=1, data unchanged.
- p==1, s in {1,2,4,8,16}: error in a check bit; sec=1, data unchanged.
- p==1, s a data position (3..21, not a power of 2): sec=1; flip that data bit if CORRECT_EN.
- p==1, s in 22..31: invalid position; ded=1, sec=0, data passed raw.
- p==0, s!=0: double error; ded=1, data passed raw.

Outputs and pipeline:
- out_data, out_syndrome, out_sec, out_ded are registered.
- They hold their last value when out_valid=0.
- out_sec and out_ded are qualified only by out_valid; they are never both 1.
- Latency is fixed at 2 cycles with full throughput: back-to-back in_valid gives back-to-back out_valid.
- No backpressure.

Counters:
- Each counter increments by 1 on a cycle where out_valid and the matching flag are 1.
- Counters saturate at 2^CNT_W-1 and never wrap.
- ded_sticky is set on the same edge as the ded_count increment.

clr_counts:
- Zeroes both counters and ded_sticky on the next edge.
- Has priority: an event retiring in the same cycle is not counted and does not set the sticky flag.
- Does not affect the pipeline contents.

Reset:
- rst=1 gives, on the next edge: out_valid=0, out_data=0, out_syndrome=0, out_sec=0, out_ded=0, both counters 0, ded_sticky=0.
- Pipeline valids are cleared, so in-flight words are dropped and never emerge.
- rst has priority over in_valid and clr_counts.
- in_valid during rst is ignored.

Test Plan:
1. Clean stream: rst 1 cycle, then in_data 0x0000..0x002C with correct check bits on consecutive cycles → out_valid 2 cycles later each cycle, out_data matches input, sec=ded=0, counters stay 0.
2. Single data error: data 0x0000/check 0x00 with data[3] flipped (in_data 0x0008) → out_syndrome 7, out_sec=1, out_data 0x0000, sec_count 1. With CORRECT_EN=0 → out_data 0x0008.
3. Check-bit errors: in_check 0x20 with data 0 → syndrome 0, out_sec=1, data 0x0000. in_check 0x01 → syndrome 1, out_sec=1.
4. Double and invalid errors:
   - in_data 0x0003, check 0x00 → syndrome 6, p=0, out_ded=1, out_data 0x0003, ded_sticky=1.
   - in_data 0x0003, check 0x10 → syndrome 22, p=1, out_ded=1, out_sec=0.
5. Saturation and clear: CNT_W=4, 17 consecutive single errors → sec_count stops at 15. Then clr_counts asserted in the same cycle a double error retires → ded_count 0, ded_sticky 0.
6. Reset mid-flight: assert rst the cycle after an in_valid carrying an error → that word never produces out_valid, all outputs 0, counters 0. The next valid word after rst is processed normally with 2-cycle latency.
